// File: rtl/fsm_out_misr_monitor_pkg.sv
// Shared types and constants for the FSM y-output MISR monitor.
package fsm_mon_pkg;

    localparam int MON_WIDTH = 23;

    // x^23 + x^5 + 1 feedback mask
    localparam logic [MON_WIDTH-1:0] DEFAULT_TAPS = 23'h000021;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } mon_state_t;

endpackage

// File: rtl/fsm_out_misr_monitor_misr_core.sv
// Multiple-input signature register: shift left, fold the MSB back through
// the tap mask, and XOR in the parallel input word.
module misr_core
    import fsm_mon_pkg::*;
#(
    parameter int               WIDTH = MON_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] feedback;

    assign feedback = q[WIDTH-1] ? TAPS : '0;

    // Signature register; clear wins over a same-cycle update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[WIDTH-2:0], 1'b0} ^ feedback ^ d;
        end
    end

endmodule

// File: rtl/fsm_out_misr_monitor.sv
// Compacts the controller FSM's y-output vector over a programmed window of
// valid samples, compares the signature with a golden value, and flags long
// runs of all-zero samples (suppressed outputs).
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | out of reset, waiting for start
//   RUN   | compacting valid samples until the window count is consumed
//   CMP   | one cycle: latch signature, compare to golden, pulse done
//   DONE  | results held; start opens a new window
module fsm_out_misr_monitor
    import fsm_mon_pkg::*;
#(
    parameter int               WIDTH       = MON_WIDTH,
    parameter int               CNT_W       = 16,
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(DEFAULT_TAPS),
    parameter int               SILENCE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] window_len,
    input  logic [WIDTH-1:0] golden,
    input  logic [WIDTH-1:0] y_vec,
    input  logic             y_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic             silence_alarm,
    output logic [CNT_W-1:0] zero_run_max
);

    localparam logic [CNT_W-1:0] SIL_LIMIT = CNT_W'(SILENCE_MAX);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

    mon_state_t       state, state_nxt;
    logic [CNT_W-1:0] remain;
    logic [CNT_W-1:0] zrun;
    logic [CNT_W-1:0] zrun_inc;
    logic [WIDTH-1:0] golden_q;
    logic [WIDTH-1:0] misr_q;
    logic             accept;
    logic             sample;

    // start only counts when no window is in flight
    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign sample   = (state == RUN) && y_valid;
    assign zrun_inc = (zrun == CNT_SAT) ? zrun : zrun + 1'b1;
    assign busy     = (state == RUN) || (state == CMP);

    misr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (sample),
        .d   (y_vec),
        .q   (misr_q)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; an empty window skips straight to the compare.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (window_len == '0) ? CMP : RUN;
                end
            end
            RUN: begin
                if (sample && (remain == CNT_W'(1))) begin
                    state_nxt = CMP;
                end
            end
            CMP:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Window counter, zero-run tracking and result latching.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remain        <= '0;
            golden_q      <= '0;
            signature     <= '0;
            pass          <= 1'b0;
            done          <= 1'b0;
            zrun          <= '0;
            zero_run_max  <= '0;
            silence_alarm <= 1'b0;
        end else begin
            done <= (state == CMP);
            if (accept) begin
                remain        <= window_len;
                golden_q      <= golden;
                signature     <= '0;
                pass          <= 1'b0;
                zrun          <= '0;
                zero_run_max  <= '0;
                silence_alarm <= 1'b0;
            end else if (sample) begin
                remain <= remain - 1'b1;
                if (y_vec == '0) begin
                    zrun <= zrun_inc;
                    if (zrun_inc > zero_run_max) begin
                        zero_run_max <= zrun_inc;
                    end
                    if (zrun_inc > SIL_LIMIT) begin
                        silence_alarm <= 1'b1;
                    end
                end else begin
                    zrun <= '0;
                end
            end
            if (state == CMP) begin
                signature <= misr_q;
                pass      <= (misr_q == golden_q);
            end
        end
    end

endmodule

// File: tb/tb_fsm_out_misr_monitor.sv
// Directed bench for the y-output MISR monitor: a window-level reference model
// checked every falling edge, plus literal expectations for the key scenarios.
module tb_fsm_out_misr_monitor;

    localparam int             W      = 23;
    localparam int             CW     = 16;
    localparam logic [W-1:0]   TAPS_M = 23'h000021;
    localparam int             SIL    = 4;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          start      = 1'b0;
    logic [CW-1:0] window_len = '0;
    logic [W-1:0]  golden     = '0;
    logic [W-1:0]  y_vec      = '0;
    logic          y_valid    = 1'b0;

    logic          busy;
    logic          done;
    logic          pass;
    logic [W-1:0]  signature;
    logic          silence_alarm;
    logic [CW-1:0] zero_run_max;

    int n_checks = 0;
    int n_errors = 0;

    fsm_out_misr_monitor dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .window_len    (window_len),
        .golden        (golden),
        .y_vec         (y_vec),
        .y_valid       (y_valid),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .signature     (signature),
        .silence_alarm (silence_alarm),
        .zero_run_max  (zero_run_max)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference signature of a sample list.
    function automatic logic [W-1:0] misr_of(input logic [W-1:0] s[$]);
        logic [W-1:0] acc = '0;
        foreach (s[i]) begin
            acc = (acc << 1) ^ (acc[W-1] ? TAPS_M : '0) ^ s[i];
        end
        return acc;
    endfunction

    // Longest stretch of consecutive all-zero samples in a list.
    function automatic int longest_zero_run(input logic [W-1:0] s[$]);
        int best = 0;
        int cur  = 0;
        foreach (s[i]) begin
            if (s[i] == '0) begin
                cur++;
                if (cur > best) best = cur;
            end else begin
                cur = 0;
            end
        end
        return best;
    endfunction

    // Window-level model: collects the window's samples and derives outputs.
    bit           m_active;
    bit           m_cmp;
    int           m_need;
    logic [W-1:0] m_samples[$];
    logic [W-1:0] m_gold;
    logic         e_busy, e_done, e_pass, e_alarm;
    logic [W-1:0] e_sig;
    int           e_zmax;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0; m_cmp = 0; m_need = 0; m_samples.delete(); m_gold = '0;
            e_busy = 0; e_done = 0; e_pass = 0; e_alarm = 0; e_sig = '0; e_zmax = 0;
        end else begin
            e_done = 0;
            if (m_cmp) begin
                e_sig  = misr_of(m_samples);
                e_pass = (e_sig == m_gold);
                e_done = 1;
                m_cmp  = 0;
            end else if (!m_active && start) begin
                m_need = int'(window_len);
                m_gold = golden;
                m_samples.delete();
                e_sig = '0; e_pass = 0; e_alarm = 0; e_zmax = 0;
                if (m_need == 0) m_cmp = 1;
                else             m_active = 1;
            end else if (m_active && y_valid) begin
                m_samples.push_back(y_vec);
                e_zmax  = longest_zero_run(m_samples);
                e_alarm = (e_zmax > SIL);
                if (m_samples.size() == m_need) begin
                    m_active = 0;
                    m_cmp    = 1;
                end
            end
            e_busy = m_active || m_cmp;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("busy",          32'(busy),          32'(e_busy));
        check("done",          32'(done),          32'(e_done));
        check("pass",          32'(pass),          32'(e_pass));
        check("signature",     32'(signature),     32'(e_sig));
        check("silence_alarm", 32'(silence_alarm), 32'(e_alarm));
        check("zero_run_max",  32'(zero_run_max),  32'(e_zmax));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_window(input int len, input logic [W-1:0] gold);
        start      = 1'b1;
        window_len = CW'(len);
        golden     = gold;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] v, input logic valid);
        y_vec   = v;
        y_valid = valid;
        tick();
        y_valid = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_signature", 32'(signature),     32'd0);
        check("rst_zmax",      32'(zero_run_max),  32'd0);
        rst = 1'b0;
        tick();

        // single sample window
        start_window(1, 23'h000001);
        send(23'h000001, 1'b1);
        tick();
        check("t1_done", 32'(done),      32'd1);
        check("t1_sig",  32'(signature), 32'h000001);
        check("t1_pass", 32'(pass),      32'd1);
        tick();

        // MSB feedback
        start_window(2, 23'h000000);
        send(23'h400000, 1'b1);
        send(23'h000000, 1'b1);
        tick();
        check("t2_sig",  32'(signature), 32'h000021);
        check("t2_pass", 32'(pass),      32'd0);
        tick();

        // empty window
        start_window(0, 23'h000000);
        tick();
        check("t3_done", 32'(done),      32'd1);
        check("t3_sig",  32'(signature), 32'd0);
        check("t3_pass", 32'(pass),      32'd1);
        tick();

        // silence alarm
        start_window(8, 23'h000000);
        send(23'h000001, 1'b1);
        for (int i = 0; i < 4; i++) send(23'h000000, 1'b1);
        check("t4_alarm_4z", 32'(silence_alarm), 32'd0);
        send(23'h000000, 1'b1);
        check("t4_alarm_5z", 32'(silence_alarm), 32'd1);
        send(23'h000003, 1'b1);
        send(23'h000000, 1'b1);
        tick();
        check("t4_done",  32'(done),          32'd1);
        check("t4_alarm", 32'(silence_alarm), 32'd1);
        check("t4_zmax",  32'(zero_run_max),  32'd5);
        tick();

        // gap-free reference window
        start_window(4, 23'h00008D);
        send(23'h400001, 1'b1);
        send(23'h000003, 1'b1);
        send(23'h000005, 1'b1);
        send(23'h000007, 1'b1);
        tick();
        check("t5a_sig",  32'(signature), 32'h00008D);
        check("t5a_pass", 32'(pass),      32'd1);
        tick();

        // same samples with valid gaps and a stray start mid-window
        start_window(4, 23'h00008D);
        send(23'h400001, 1'b1);
        start      = 1'b1;
        window_len = 16'd1;
        golden     = 23'h000000;
        send(23'h7FFFFF, 1'b0);
        start = 1'b0;
        send(23'h000003, 1'b1);
        send(23'h123456, 1'b0);
        send(23'h000005, 1'b1);
        check("t5_busy", 32'(busy), 32'd1);
        send(23'h000007, 1'b1);
        tick();
        check("t5_done", 32'(done),      32'd1);
        check("t5_sig",  32'(signature), 32'h00008D);
        check("t5_pass", 32'(pass),      32'd1);
        tick();

        // reset mid-window
        start_window(4, 23'h000000);
        send(23'h000001, 1'b1);
        send(23'h000002, 1'b1);
        rst = 1'b1;
        #2;
        check("t6_busy",  32'(busy),      32'd0);
        check("t6_done",  32'(done),      32'd0);
        check("t6_sig",   32'(signature), 32'd0);
        check("t6_pass",  32'(pass),      32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("t6_idle_done", 32'(done), 32'd0);
        start_window(1, 23'h000005);
        send(23'h000005, 1'b1);
        tick();
        check("t6b_done", 32'(done),      32'd1);
        check("t6b_sig",  32'(signature), 32'h000005);
        check("t6b_pass", 32'(pass),      32'd1);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
